// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: word/register widths, EX/MEM and MEM/WB
// register layouts and the bubble constants loaded on stall/flush.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic [WORD_W-1:0] alu_out;
        logic [WORD_W-1:0] write_data;
        logic [REG_W-1:0]  write_reg;
    } exMemT;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [WORD_W-1:0] alu_out;
        logic [WORD_W-1:0] read_data;
        logic [REG_W-1:0]  write_reg;
    } memWbT;

    localparam exMemT EXMEM_BUBBLE = '0;
    localparam memWbT MEMWB_BUBBLE = '0;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: DEPTH x 32, synchronous write, async read.
// Ports: clk, we, addr (word address), wdata, rdata.
module data_memory
    import mips_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    // Contents are deliberately not reset.
    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory access, MEM/WB register
// and write-back mux. Inputs are EX-stage results plus stallM/flushM;
// outputs are M-stage forwarding taps, alignErrM and the W-stage result.
module memory_access_stage
    import mips_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              regWriteE,
    input  logic              memToRegE,
    input  logic              memWriteE,
    input  logic [WORD_W-1:0] aluOutE,
    input  logic [WORD_W-1:0] writeDataE,
    input  logic [REG_W-1:0]  writeRegE,
    input  logic              stallM,
    input  logic              flushM,
    output logic              regWriteM,
    output logic [WORD_W-1:0] aluOutM,
    output logic [REG_W-1:0]  writeRegM,
    output logic              regWriteW,
    output logic [REG_W-1:0]  writeRegW,
    output logic [WORD_W-1:0] resultW,
    output logic              alignErrM
);

    localparam int ADDR_W = $clog2(DEPTH);

    exMemT ex_mem_q, ex_mem_d;
    memWbT mem_wb_q, mem_wb_d;

    logic [WORD_W-1:0] read_data_m;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              unused_addr_bits;

    // Upper byte-address bits are dropped: addresses wrap modulo DEPTH.
    assign mem_addr         = ex_mem_q.alu_out[ADDR_W+1:2];
    assign unused_addr_bits = ^ex_mem_q.alu_out[WORD_W-1:ADDR_W+2];

    assign alignErrM = (ex_mem_q.mem_write | ex_mem_q.mem_to_reg)
                     & (ex_mem_q.alu_out[1:0] != 2'b00);

    // A stalled store waits; a misaligned store never writes.
    assign mem_we = ex_mem_q.mem_write & ~stallM & ~alignErrM;

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (flushM) begin
            ex_mem_d = EXMEM_BUBBLE;
        end else if (!stallM) begin
            ex_mem_d = '{
                reg_write:  regWriteE & (writeRegE != '0),
                mem_to_reg: memToRegE,
                mem_write:  memWriteE,
                alu_out:    aluOutE,
                write_data: writeDataE,
                write_reg:  writeRegE
            };
        end
    end

    always_comb begin
        mem_wb_d = MEMWB_BUBBLE;
        if (!stallM) begin
            mem_wb_d = '{
                reg_write:  ex_mem_q.reg_write,
                mem_to_reg: ex_mem_q.mem_to_reg,
                alu_out:    ex_mem_q.alu_out,
                read_data:  read_data_m,
                write_reg:  ex_mem_q.write_reg
            };
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ex_mem_q <= EXMEM_BUBBLE;
            mem_wb_q <= MEMWB_BUBBLE;
        end else begin
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    data_memory #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (ex_mem_q.write_data),
        .rdata (read_data_m)
    );

    assign regWriteM = ex_mem_q.reg_write;
    assign aluOutM   = ex_mem_q.alu_out;
    assign writeRegM = ex_mem_q.write_reg;

    assign regWriteW = mem_wb_q.reg_write;
    assign writeRegW = mem_wb_q.write_reg;
    assign resultW   = mem_wb_q.mem_to_reg ? mem_wb_q.read_data
                                           : mem_wb_q.alu_out;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios followed
// by random instruction traffic against an instruction-level model.
module tb_memory_access_stage;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        resetN;
    logic        regWriteE, memToRegE, memWriteE;
    logic [31:0] aluOutE, writeDataE;
    logic [4:0]  writeRegE;
    logic        stallM, flushM;
    logic        regWriteM;
    logic [31:0] aluOutM;
    logic [4:0]  writeRegM;
    logic        regWriteW;
    logic [4:0]  writeRegW;
    logic [31:0] resultW;
    logic        alignErrM;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_access_stage #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .regWriteE  (regWriteE),
        .memToRegE  (memToRegE),
        .memWriteE  (memWriteE),
        .aluOutE    (aluOutE),
        .writeDataE (writeDataE),
        .writeRegE  (writeRegE),
        .stallM     (stallM),
        .flushM     (flushM),
        .regWriteM  (regWriteM),
        .aluOutM    (aluOutM),
        .writeRegM  (writeRegM),
        .regWriteW  (regWriteW),
        .writeRegW  (writeRegW),
        .resultW    (resultW),
        .alignErrM  (alignErrM)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction-level model: the one instruction sitting in MEM, the
    // last retired instruction's write-back, and the memory image.
    typedef struct packed {
        logic        rw;
        logic        ld;
        logic        st;
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  rd;
    } ins_t;

    ins_t        m_ins;
    logic        w_rw;
    logic [4:0]  w_rd;
    logic [31:0] w_res;
    bit          w_known;
    logic [31:0] mref [DEPTH];
    bit          mknown [DEPTH];

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic model_reset();
        m_ins   = '0;
        w_rw    = 1'b0;
        w_rd    = '0;
        w_res   = '0;
        w_known = 1'b1;
    endtask

    task automatic model_edge();
        ins_t e;
        e.rw = regWriteE && (writeRegE != 0);
        e.ld = memToRegE;
        e.st = memWriteE;
        e.a  = aluOutE;
        e.d  = writeDataE;
        e.rd = writeRegE;
        if (stallM) begin
            w_rw    = 1'b0;
            w_rd    = '0;
            w_res   = '0;
            w_known = 1'b1;
        end else begin
            w_rw = m_ins.rw;
            w_rd = m_ins.rd;
            if (m_ins.ld) begin
                w_res   = mref[widx(m_ins.a)];
                w_known = mknown[widx(m_ins.a)];
            end else begin
                w_res   = m_ins.a;
                w_known = 1'b1;
            end
            if (m_ins.st && (m_ins.a % 4 == 0)) begin
                mref[widx(m_ins.a)]   = m_ins.d;
                mknown[widx(m_ins.a)] = 1'b1;
            end
        end
        if (flushM) m_ins = '0;
        else if (!stallM) m_ins = e;
    endtask

    task automatic check_outputs();
        chk("regWriteM", regWriteM, m_ins.rw);
        chk("aluOutM", aluOutM, m_ins.a);
        chk("writeRegM", writeRegM, m_ins.rd);
        chk("alignErrM", alignErrM,
            (m_ins.ld || m_ins.st) && (m_ins.a % 4 != 0));
        chk("regWriteW", regWriteW, w_rw);
        chk("writeRegW", writeRegW, w_rd);
        if (w_known) chk("resultW", resultW, w_res);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_in(input logic rw, input logic ld, input logic st,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] rd);
        regWriteE  = rw;
        memToRegE  = ld;
        memWriteE  = st;
        aluOutE    = a;
        writeDataE = d;
        writeRegE  = rd;
    endtask

    task automatic nop();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_regWriteM"}, regWriteM, 0);
        chk({tag, "_aluOutM"}, aluOutM, 0);
        chk({tag, "_writeRegM"}, writeRegM, 0);
        chk({tag, "_regWriteW"}, regWriteW, 0);
        chk({tag, "_writeRegW"}, writeRegW, 0);
        chk({tag, "_resultW"}, resultW, 0);
        chk({tag, "_alignErrM"}, alignErrM, 0);
    endtask

    initial begin
        resetN = 1'b0;
        stallM = 1'b0;
        flushM = 1'b0;
        nop();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        resetN = 1'b1;

        // ALU result through both stages
        set_in(1'b1, 1'b0, 1'b0, 32'd22, 32'h0, 5'd3);
        cyc();
        chk("alu_aluOutM", aluOutM, 22);
        chk("alu_writeRegM", writeRegM, 3);
        nop();
        cyc();
        chk("alu_resultW", resultW, 22);
        chk("alu_regWriteW", regWriteW, 1);

        // Store then back-to-back load
        set_in(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
        cyc();
        set_in(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
        cyc();
        nop();
        cyc();
        chk("ld_after_st", resultW, 32'hDEADBEEF);
        chk("ld_after_st_rd", writeRegW, 5);

        // Misaligned store is flagged and suppressed
        set_in(1'b0, 1'b0, 1'b1, 32'h12, 32'h11111111, 5'd0);
        cyc();
        chk("misalign_flag", alignErrM, 1);
        set_in(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd6);
        cyc();
        nop();
        cyc();
        chk("misalign_suppressed", resultW, 32'hDEADBEEF);

        // Write to r0 is discarded
        set_in(1'b1, 1'b0, 1'b0, 32'd5, 32'h0, 5'd0);
        cyc();
        chk("r0_regWriteM", regWriteM, 0);
        nop();
        cyc();
        chk("r0_regWriteW", regWriteW, 0);

        // Store held under a 3-cycle stall; EX inputs meanwhile ignored
        set_in(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 5'd0);
        cyc();
        stallM = 1'b1;
        set_in(1'b0, 1'b0, 1'b1, 32'h20, 32'h55555555, 5'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_regWriteW", regWriteW, 0);
            chk("stall_aluOutM", aluOutM, 32'h20);
        end
        stallM = 1'b0;
        nop();
        cyc();
        set_in(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd4);
        cyc();
        nop();
        cyc();
        chk("stall_store_once", resultW, 32'hCAFEF00D);

        // flush together with stall gives a bubble
        set_in(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd7);
        cyc();
        stallM = 1'b1;
        flushM = 1'b1;
        nop();
        cyc();
        chk("fs_regWriteM", regWriteM, 0);
        chk("fs_aluOutM", aluOutM, 0);
        chk("fs_regWriteW", regWriteW, 0);
        stallM = 1'b0;
        flushM = 1'b0;

        // Address wraps modulo DEPTH words
        set_in(1'b0, 1'b0, 1'b1, 32'(4 * DEPTH + 8), 32'h12345678, 5'd0);
        cyc();
        set_in(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd8);
        cyc();
        nop();
        cyc();
        chk("wrap_load", resultW, 32'h12345678);

        // Reset while a store sits in MEM drops the store
        set_in(1'b0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 5'd0);
        cyc();
        nop();
        #2;
        resetN = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd9);
        cyc();
        nop();
        cyc();
        chk("reset_drops_store", resultW, 32'hCAFEF00D);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            a  = 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << 10);
            case (op)
                0: set_in(1'b1, 1'b0, 1'b0, $urandom, $urandom,
                          5'($urandom_range(0, 31)));
                1: set_in(1'b1, 1'b1, 1'b0, a, $urandom,
                          5'($urandom_range(0, 31)));
                2: set_in(1'b0, 1'b0, 1'b1, a, $urandom,
                          5'($urandom_range(0, 31)));
                default: set_in(1'b0, 1'b0, 1'b0, $urandom, $urandom,
                                5'($urandom_range(0, 31)));
            endcase
            stallM = ($urandom_range(0, 5) == 0);
            flushM = ($urandom_range(0, 9) == 0);
            cyc();
        end
        stallM = 1'b0;
        flushM = 1'b0;
        nop();
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
